cdb_arbiter: RTL and testbench

- Shares the single ROB result-write path between three producers: ALU reservation station (rs), load buffer (lb), store buffer (sb).
- Each producer pushes completions into a private small FIFO. A round-robin arbiter drains one entry per cycle onto a registered common data bus (CDB), which feeds the ROB and the RS/LSB wakeup logic.
- Flushed by the ROB's clear_all on branch mispredict.

---
 rtl/cdb_arbiter_pkg.sv | 17 +
 rtl/cdb_arbiter_fifo.sv | 59 +++++
 rtl/cdb_arbiter.sv | 140 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the common data bus arbiter: tag width, source
// encodings and the round-robin advance rule.
package cdb_arbiter_pkg;

  localparam int DEFAULT_ROB_WIDTH_BIT = 4;
  localparam int VALUE_W = 32;

  localparam logic [1:0] CDB_SRC_RS = 2'd0;
  localparam logic [1:0] CDB_SRC_LB = 2'd1;
  localparam logic [1:0] CDB_SRC_SB = 2'd2;

  // Priority moves to the producer after the one just granted.
  function automatic logic [1:0] next_rr(input logic [1:0] winner);
    return (winner == CDB_SRC_SB) ? CDB_SRC_RS : winner + 2'd1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_fifo.sv
// Small per-producer completion FIFO with asynchronous reset, global pause
// and a flush that empties it at the next unpaused edge.
module cdb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 36,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign head      = r_mem[r_rd_ptr];
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  // DEPTH is a power of two, so pointer wrap is the natural binary overflow.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rdy_in && !flush && w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter draining three producer FIFOs (rs, lb, sb) onto one
// registered common data bus feeding the ROB and wakeup logic.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int ROB_WIDTH_BIT = DEFAULT_ROB_WIDTH_BIT,
  parameter int FIFO_DEPTH    = 2
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rdy_in,
  input  logic                       clear_all,
  input  logic                       rs_valid,
  input  logic [ROB_WIDTH_BIT-1:0]   rs_dest,
  input  logic [31:0]                rs_value,
  output logic                       rs_ready,
  input  logic                       lb_valid,
  input  logic [ROB_WIDTH_BIT-1:0]   lb_dest,
  input  logic [31:0]                lb_value,
  output logic                       lb_ready,
  input  logic                       sb_valid,
  input  logic [ROB_WIDTH_BIT-1:0]   sb_dest,
  output logic                       sb_ready,
  output logic                       cdb_valid,
  output logic [ROB_WIDTH_BIT-1:0]   cdb_dest,
  output logic [31:0]                cdb_value,
  output logic [1:0]                 cdb_src,
  output logic [1:0]                 dbg_rr_ptr,
  output logic [$clog2(FIFO_DEPTH):0] dbg_rs_count,
  output logic [$clog2(FIFO_DEPTH):0] dbg_lb_count,
  output logic [$clog2(FIFO_DEPTH):0] dbg_sb_count
);

  localparam int DW = ROB_WIDTH_BIT + VALUE_W;

  // Handshake: an offer is taken at a posedge where rdy_in=1, clear_all=0,
  // x_valid=1 and x_ready=1; x_ready depends only on FIFO occupancy, so the
  // producer must hold valid/dest/value steady until it sees ready.
  logic          w_go;
  logic [2:0]    w_full;
  logic [2:0]    w_empty;
  logic [2:0]    w_pop;
  logic [DW-1:0] w_head [3];
  logic          w_any;
  logic [1:0]    w_win;
  logic [DW-1:0] w_win_head;

  logic                     r_cdb_valid;
  logic [ROB_WIDTH_BIT-1:0] r_cdb_dest;
  logic [31:0]              r_cdb_value;
  logic [1:0]               r_cdb_src;
  logic [1:0]               r_rr_ptr;

  assign w_go = rdy_in & ~clear_all;

  cdb_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DW)) u_rs_fifo (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(clear_all),
    .push(w_go & rs_valid), .pop(w_pop[0]), .push_data({rs_dest, rs_value}),
    .full(w_full[0]), .empty(w_empty[0]), .count(dbg_rs_count), .head(w_head[0])
  );

  cdb_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DW)) u_lb_fifo (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(clear_all),
    .push(w_go & lb_valid), .pop(w_pop[1]), .push_data({lb_dest, lb_value}),
    .full(w_full[1]), .empty(w_empty[1]), .count(dbg_lb_count), .head(w_head[1])
  );

  cdb_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DW)) u_sb_fifo (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(clear_all),
    .push(w_go & sb_valid), .pop(w_pop[2]), .push_data({sb_dest, 32'd0}),
    .full(w_full[2]), .empty(w_empty[2]), .count(dbg_sb_count), .head(w_head[2])
  );

  assign rs_ready = ~w_full[0];
  assign lb_ready = ~w_full[1];
  assign sb_ready = ~w_full[2];

  // Search starts at r_rr_ptr and wraps rs -> lb -> sb on pre-edge occupancy.
  always_comb begin
    w_any = ~&w_empty;
    w_win = CDB_SRC_RS;
    case (r_rr_ptr)
      CDB_SRC_LB: begin
        if (!w_empty[1])      w_win = CDB_SRC_LB;
        else if (!w_empty[2]) w_win = CDB_SRC_SB;
        else                  w_win = CDB_SRC_RS;
      end
      CDB_SRC_SB: begin
        if (!w_empty[2])      w_win = CDB_SRC_SB;
        else if (!w_empty[0]) w_win = CDB_SRC_RS;
        else                  w_win = CDB_SRC_LB;
      end
      default: begin
        if (!w_empty[0])      w_win = CDB_SRC_RS;
        else if (!w_empty[1]) w_win = CDB_SRC_LB;
        else                  w_win = CDB_SRC_SB;
      end
    endcase
  end

  always_comb begin
    w_pop = '0;
    if (w_go && w_any) w_pop[w_win] = 1'b1;
    case (w_win)
      CDB_SRC_LB: w_win_head = w_head[1];
      CDB_SRC_SB: w_win_head = w_head[2];
      default:    w_win_head = w_head[0];
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_cdb_valid <= 1'b0;
      r_cdb_dest  <= '0;
      r_cdb_value <= '0;
      r_cdb_src   <= CDB_SRC_RS;
      r_rr_ptr    <= CDB_SRC_RS;
    end else if (rdy_in) begin
      if (clear_all) begin
        r_cdb_valid <= 1'b0;
        r_rr_ptr    <= CDB_SRC_RS;
      end else if (w_any) begin
        r_cdb_valid <= 1'b1;
        r_cdb_dest  <= w_win_head[DW-1:VALUE_W];
        r_cdb_value <= w_win_head[VALUE_W-1:0];
        r_cdb_src   <= w_win;
        r_rr_ptr    <= next_rr(w_win);
      end else begin
        r_cdb_valid <= 1'b0;
      end
    end
  end

  assign cdb_valid  = r_cdb_valid;
  assign cdb_dest   = r_cdb_dest;
  assign cdb_value  = r_cdb_value;
  assign cdb_src    = r_cdb_src;
  assign dbg_rr_ptr = r_rr_ptr;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed vector table plus hand-written reset/stream sequences for the
// common data bus arbiter.
module tb_cdb_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clear_all;
  logic        rs_valid, lb_valid, sb_valid;
  logic [3:0]  rs_dest, lb_dest, sb_dest;
  logic [31:0] rs_value, lb_value;
  logic        rs_ready, lb_ready, sb_ready;
  logic        cdb_valid;
  logic [3:0]  cdb_dest;
  logic [31:0] cdb_value;
  logic [1:0]  cdb_src;
  logic [1:0]  dbg_rr_ptr;
  logic [1:0]  dbg_rs_count, dbg_lb_count, dbg_sb_count;

  int checks = 0;
  int failures = 0;
  logic [35:0] exp_q[$];

  cdb_arbiter #(.ROB_WIDTH_BIT(4), .FIFO_DEPTH(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_all(clear_all),
    .rs_valid(rs_valid), .rs_dest(rs_dest), .rs_value(rs_value), .rs_ready(rs_ready),
    .lb_valid(lb_valid), .lb_dest(lb_dest), .lb_value(lb_value), .lb_ready(lb_ready),
    .sb_valid(sb_valid), .sb_dest(sb_dest), .sb_ready(sb_ready),
    .cdb_valid(cdb_valid), .cdb_dest(cdb_dest), .cdb_value(cdb_value), .cdb_src(cdb_src),
    .dbg_rr_ptr(dbg_rr_ptr), .dbg_rs_count(dbg_rs_count),
    .dbg_lb_count(dbg_lb_count), .dbg_sb_count(dbg_sb_count)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        rdy, clr;
    logic        rv;  logic [3:0] rd; logic [31:0] rval;
    logic        lv;  logic [3:0] ld; logic [31:0] lval;
    logic        sv;  logic [3:0] sd;
    logic        ev;  logic [3:0] ed; logic [31:0] exp_val; logic [1:0] es;
    logic [2:0]  erdy;  // {sb, lb, rs}
    logic [1:0]  err;
  } vec_t;

  localparam int NV = 38;
  vec_t vecs[NV];

  function automatic vec_t mk(
    input logic rdy, input logic clr,
    input logic rv, input logic [3:0] rd, input logic [31:0] rval,
    input logic lv, input logic [3:0] ld, input logic [31:0] lval,
    input logic sv, input logic [3:0] sd,
    input logic ev, input logic [3:0] ed, input logic [31:0] xv, input logic [1:0] es,
    input logic [2:0] erdy, input logic [1:0] err);
    vec_t v;
    v.rdy = rdy; v.clr = clr;
    v.rv = rv; v.rd = rd; v.rval = rval;
    v.lv = lv; v.ld = ld; v.lval = lval;
    v.sv = sv; v.sd = sd;
    v.ev = ev; v.ed = ed; v.exp_val = xv; v.es = es;
    v.erdy = erdy; v.err = err;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rdy_in = 1'b1; clear_all = 1'b0;
    rs_valid = 1'b0; rs_dest = '0; rs_value = '0;
    lb_valid = 1'b0; lb_dest = '0; lb_value = '0;
    sb_valid = 1'b0; sb_dest = '0;
  endtask

  // driver
  task automatic apply(input vec_t v);
    rdy_in = v.rdy; clear_all = v.clr;
    rs_valid = v.rv; rs_dest = v.rd; rs_value = v.rval;
    lb_valid = v.lv; lb_dest = v.ld; lb_value = v.lval;
    sb_valid = v.sv; sb_dest = v.sd;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_cdb"}, 64'({cdb_valid, cdb_dest, cdb_value, cdb_src}), 64'd0);
    check({tag, "_ready"}, 64'({sb_ready, lb_ready, rs_ready}), 64'h7);
    check({tag, "_counts_rr"},
          64'({dbg_rs_count, dbg_lb_count, dbg_sb_count, dbg_rr_ptr}), 64'd0);
  endtask

  initial begin
    // all three offer at once, rr_ptr=0
    vecs[0]  = mk(1,0, 1,1,32'h11, 1,2,32'h22, 1,3, 0,0,32'h0,0, 3'b111,0);
    vecs[1]  = mk(1,0, 0,0,0, 0,0,0, 0,0,      1,1,32'h11,0, 3'b111,1);
    vecs[2]  = mk(1,0, 0,0,0, 0,0,0, 0,0,      1,2,32'h22,1, 3'b111,2);
    vecs[3]  = mk(1,0, 0,0,0, 0,0,0, 0,0,      1,3,32'h0,2,  3'b111,0);
    vecs[4]  = mk(1,0, 0,0,0, 0,0,0, 0,0,      0,3,32'h0,2,  3'b111,0);
    // single rs offer, one-cycle latency
    vecs[5]  = mk(1,0, 1,3,32'h1234, 0,0,0, 0,0, 0,3,32'h0,2,    3'b111,0);
    vecs[6]  = mk(1,0, 0,0,0, 0,0,0, 0,0,        1,3,32'h1234,0, 3'b111,1);
    vecs[7]  = mk(1,0, 0,0,0, 0,0,0, 0,0,        0,3,32'h1234,0, 3'b111,1);
    // rs streams five dests back to back
    vecs[8]  = mk(1,0, 1,4,32'h104, 0,0,0, 0,0, 0,3,32'h1234,0, 3'b111,1);
    vecs[9]  = mk(1,0, 1,5,32'h105, 0,0,0, 0,0, 1,4,32'h104,0,  3'b111,1);
    vecs[10] = mk(1,0, 1,6,32'h106, 0,0,0, 0,0, 1,5,32'h105,0,  3'b111,1);
    vecs[11] = mk(1,0, 1,7,32'h107, 0,0,0, 0,0, 1,6,32'h106,0,  3'b111,1);
    vecs[12] = mk(1,0, 1,8,32'h108, 0,0,0, 0,0, 1,7,32'h107,0,  3'b111,1);
    vecs[13] = mk(1,0, 0,0,0, 0,0,0, 0,0,       1,8,32'h108,0,  3'b111,1);
    vecs[14] = mk(1,0, 0,0,0, 0,0,0, 0,0,       0,8,32'h108,0,  3'b111,1);
    // fill rs and sb to 2 entries, then flush
    vecs[15] = mk(1,0, 1,1,32'hA1, 1,2,32'hB2, 1,3, 0,8,32'h108,0, 3'b111,1);
    vecs[16] = mk(1,0, 1,4,32'hA4, 1,5,32'hB5, 1,6, 1,2,32'hB2,1,  3'b010,2);
    vecs[17] = mk(1,1, 1,7,32'hA7, 1,8,32'hB8, 1,9, 0,2,32'hB2,1,  3'b111,0);
    vecs[18] = mk(1,0, 0,0,0, 0,0,0, 0,0,              0,2,32'hB2,1,  3'b111,0);
    vecs[19] = mk(1,0, 1,10,32'hAA, 1,9,32'hC9, 0,0,   0,2,32'hB2,1,  3'b111,0);
    vecs[20] = mk(1,0, 0,0,0, 0,0,0, 0,0,              1,10,32'hAA,0, 3'b111,1);
    vecs[21] = mk(1,0, 0,0,0, 0,0,0, 0,0,              1,9,32'hC9,1,  3'b111,2);
    vecs[22] = mk(1,0, 0,0,0, 0,0,0, 0,0,              0,9,32'hC9,1,  3'b111,2);
    // pause with lb queued and cdb_valid high; clear/offer while paused ignored
    vecs[23] = mk(1,0, 1,1,32'h51, 1,2,32'h62, 0,0, 0,9,32'hC9,1, 3'b111,2);
    vecs[24] = mk(1,0, 0,0,0, 0,0,0, 0,0,           1,1,32'h51,0, 3'b111,1);
    vecs[25] = mk(0,1, 0,0,0, 0,0,0, 1,7,           1,1,32'h51,0, 3'b111,1);
    vecs[26] = mk(0,0, 0,0,0, 0,0,0, 0,0,           1,1,32'h51,0, 3'b111,1);
    vecs[27] = mk(0,0, 0,0,0, 0,0,0, 0,0,           1,1,32'h51,0, 3'b111,1);
    vecs[28] = mk(1,0, 0,0,0, 0,0,0, 0,0,           1,2,32'h62,1, 3'b111,2);
    vecs[29] = mk(1,0, 0,0,0, 0,0,0, 0,0,           0,2,32'h62,1, 3'b111,2);
    // offer to a full FIFO is dropped (dest 7 never appears)
    vecs[30] = mk(1,0, 1,1,32'h1, 1,2,32'h2, 1,3, 0,2,32'h62,1, 3'b111,2);
    vecs[31] = mk(1,0, 1,4,32'h4, 1,5,32'h5, 1,6, 1,3,32'h0,2,  3'b100,0);
    vecs[32] = mk(1,0, 1,7,32'h7, 0,0,0, 0,0,     1,1,32'h1,0,  3'b101,1);
    vecs[33] = mk(1,0, 0,0,0, 0,0,0, 0,0,         1,2,32'h2,1,  3'b111,2);
    vecs[34] = mk(1,0, 0,0,0, 0,0,0, 0,0,         1,6,32'h0,2,  3'b111,0);
    vecs[35] = mk(1,0, 0,0,0, 0,0,0, 0,0,         1,4,32'h4,0,  3'b111,1);
    vecs[36] = mk(1,0, 0,0,0, 0,0,0, 0,0,         1,5,32'h5,1,  3'b111,2);
    vecs[37] = mk(1,0, 0,0,0, 0,0,0, 0,0,         0,5,32'h5,1,  3'b111,2);

    idle_inputs();
    rst_in = 1'b1;
    #1;
    check_reset_state("reset");
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;

    for (int i = 0; i < NV; i++) begin
      apply(vecs[i]);
      @(posedge clk_in);
      #1;
      check($sformatf("v%0d_cdb", i),
            64'({cdb_valid, cdb_dest, cdb_value, cdb_src}),
            64'({vecs[i].ev, vecs[i].ed, vecs[i].exp_val, vecs[i].es}));
      check($sformatf("v%0d_ready_rr", i),
            64'({sb_ready, lb_ready, rs_ready, dbg_rr_ptr}),
            64'({vecs[i].erdy, vecs[i].err}));
    end

    // async reset mid-cycle with cdb_valid high and lb still queued
    idle_inputs();
    rs_valid = 1'b1; rs_dest = 4'hA; rs_value = 32'h77;
    lb_valid = 1'b1; lb_dest = 4'hB; lb_value = 32'h88;
    @(posedge clk_in); #1;
    idle_inputs();
    @(posedge clk_in); #1;
    check("arst_pre_cdb", 64'({cdb_valid, cdb_dest, cdb_value, cdb_src}),
          64'({1'b1, 4'hA, 32'h77, 2'd0}));
    #2;
    rst_in = 1'b1;
    #1;
    check_reset_state("arst");
    @(negedge clk_in);
    rst_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk_in); #1;
      check($sformatf("arst_post%0d", i), 64'({cdb_valid, dbg_lb_count}), 64'd0);
    end

    // lb stream with random pauses; scoreboard in acceptance order
    begin
      logic acc;
      logic edge_rdy;
      idle_inputs();
      for (int c = 0; c < 60; c++) begin
        if (c < 45) begin
          rdy_in = ($urandom_range(0, 3) != 0);
          if (!lb_valid) begin
            lb_valid = ($urandom_range(0, 2) != 0);
            lb_dest  = 4'($urandom_range(0, 15));
            lb_value = $urandom;
          end
        end else begin
          rdy_in = 1'b1;
          lb_valid = 1'b0;
        end
        acc = lb_valid && lb_ready && rdy_in;
        edge_rdy = rdy_in;
        @(posedge clk_in); #1;
        if (edge_rdy && cdb_valid) begin
          if (exp_q.size() == 0) begin
            check("stream_unexpected", 64'(cdb_dest), 64'hDEAD);
          end else begin
            check($sformatf("stream_c%0d", c),
                  64'({cdb_dest, cdb_value, cdb_src}),
                  64'({exp_q.pop_front(), 2'd1}));
          end
        end
        if (acc) begin
          exp_q.push_back({lb_dest, lb_value});
          lb_valid = 1'b0;
        end
      end
      check("stream_drained", 64'(exp_q.size()), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
